// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding register feeding a 10-bit 8N1 shift register.
// Bit timing comes from brg_en, OVERSAMPLE ticks per bit.
module spart_tx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus,
    input  logic       brg_en,
    output logic       tbr,
    output logic       tx_busy,
    output logic       txd
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_STOP  = 4'd9;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             full_q, full_d;
    logic [9:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [3:0]       bit_q, bit_d;
    logic             txd_q, txd_d;
    logic             wr_acc;
    logic             load;

    // A write can only land while the holding register is empty, so it never
    // collides with a load, which needs the holding register full.
    assign wr_acc = iocs && !iorw && (ioaddr == 2'b00) && !full_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        full_d  = full_q;
        shreg_d = shreg_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        load    = 1'b0;

        if (wr_acc) begin
            hold_d = databus;
            full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (full_q) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (brg_en) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_STOP) begin
                            if (full_q) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                                txd_d   = 1'b1;
                                bit_d   = '0;
                            end
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shreg_d = {1'b1, shreg_q[9:1]};
                            txd_d   = shreg_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load overrides the stop-bit handling so back-to-back frames have no gap.
        if (load) begin
            state_d = SHIFT;
            shreg_d = {1'b1, hold_q, 1'b0};
            full_d  = 1'b0;
            txd_d   = 1'b0;
            tick_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            full_q  <= 1'b0;
            shreg_q <= '1;
            tick_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            shreg_q <= shreg_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    assign tbr     = !full_q;
    assign tx_busy = (state_q == SHIFT);
    assign txd     = txd_q;

endmodule
